// File: rtl/rtu_frame_tx_if.sv
// Bus bundle between a Modbus response requester, its register map and the
// RTU frame transmitter. The transmitter is the slave side.
interface rtu_frame_tx_if #(
  parameter int unsigned DATA_W = 16
) ();
  logic              tx_start;
  logic [7:0]        slave_addr;
  logic [7:0]        func_code;
  logic [7:0]        tx_quantity;
  logic              exc_req;
  logic [7:0]        exc_code;
  logic              rd_en;
  logic [7:0]        rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic              response_done;
  logic              rs485_tx;
  logic              rs485_tx_en;

  modport master (
    output tx_start, slave_addr, func_code, tx_quantity, exc_req, exc_code, rd_data,
    input  rd_en, rd_addr, busy, response_done, rs485_tx, rs485_tx_en
  );

  modport slave (
    input  tx_start, slave_addr, func_code, tx_quantity, exc_req, exc_code, rd_data,
    output rd_en, rd_addr, busy, response_done, rs485_tx, rs485_tx_en
  );
endinterface

// File: rtl/rtu_frame_tx.sv
// Modbus RTU response transmitter: builds addr/func/count/data/CRC frames,
// serializes them as UART characters and wraps them in RS-485 guard time.
// The next byte is prepared during the final stop bit (or final pre-gap bit),
// so BPS_PARAM must be at least 5 and GAP_BITS at least 2.
module rtu_frame_tx #(
  parameter int unsigned CLK_FREQ  = 50000000,
  parameter int unsigned BAUD_RATE = 9600,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1,
  parameter int unsigned GAP_BITS  = 35,
  parameter int unsigned MAX_BYTES = 250
) (
  input logic clk_in,
  input logic rst_n_in,
  rtu_frame_tx_if.slave bus
);

  localparam int unsigned BpsParam = CLK_FREQ / BAUD_RATE;
  localparam int unsigned Bytes    = DATA_W / 8;
  localparam int unsigned NBits    = 10 + ((PARITY != 0) ? 1 : 0) + (STOP_BITS - 1);
  localparam int unsigned CntW     = (BpsParam > 1) ? $clog2(BpsParam) : 1;
  localparam logic [CntW-1:0] BaudLast = CntW'(BpsParam - 1);
  localparam logic [7:0] GapLast  = 8'(GAP_BITS - 1);
  localparam logic [7:0] GapTurn  = 8'(GAP_BITS - 2);
  localparam logic [7:0] BitLast  = 8'(NBits - 1);
  localparam logic [7:0] BitTurn  = 8'(NBits - 2);
  localparam logic [1:0] BselLast = 2'(Bytes - 1);

  typedef enum logic [2:0] {
    StIdle, StPreGap, StLoad, StSend, StCrcLo, StCrcHi, StPostGap, StDone
  } state_e;
  typedef enum logic [1:0] {KindData, KindCrcLo, KindCrcHi} kind_e;

  state_e            state_q;
  kind_e             kind_q;
  logic [2:0]        start_sync_q;
  logic [7:0]        addr_q, func_q, code_q, nbytes_q;
  logic              exc_q;
  logic [8:0]        idx_q;
  logic [7:0]        reg_idx_q;
  logic [1:0]        bsel_q;
  logic [1:0]        rd_pend_q;
  logic [DATA_W-1:0] data_sr_q;
  logic [7:0]        nxt_q;
  logic              rdy_q;
  logic [10:0]       sr_q;
  logic [CntW-1:0]   baud_q;
  logic [7:0]        bit_q;
  logic [15:0]       crc_q;
  logic              tx_q, en_q, busy_q, done_q, rd_en_q;
  logic [7:0]        rd_addr_q;

  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {8'h00, b};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    end
    return r;
  endfunction

  // Bits following the start bit, LSB first; unused high bits double as stop bits.
  function automatic logic [10:0] char_bits(input logic [7:0] b);
    logic [10:0] r;
    r = '1;
    r[7:0] = b;
    if (PARITY == 1) r[8] = ~^b;
    else if (PARITY == 2) r[8] = ^b;
    return r;
  endfunction

  logic        start_edge, tick, force_exc, is_hdr, is_data, launch;
  logic [15:0] prod, crc_next;
  logic [8:0]  ndata;
  logic [7:0]  hdr_byte, ld_byte;

  // Start edge, legality of the request and the byte to be loaded next.
  always_comb begin
    start_edge = start_sync_q[1] & ~start_sync_q[2];
    tick       = (baud_q == BaudLast);
    prod       = 16'(bus.tx_quantity) * 16'(Bytes);
    force_exc  = ~bus.exc_req & ((bus.tx_quantity == 8'd0) | (prod > 16'(MAX_BYTES)));
    ndata      = exc_q ? 9'd0 : {1'b0, nbytes_q};
    is_hdr     = (idx_q < 9'd3);
    is_data    = (idx_q < (9'd3 + ndata));
    case (idx_q[1:0])
      2'd0:    hdr_byte = addr_q;
      2'd1:    hdr_byte = exc_q ? (func_q | 8'h80) : func_q;
      default: hdr_byte = exc_q ? code_q : nbytes_q;
    endcase
    if (is_hdr)              ld_byte = hdr_byte;
    else if (bsel_q == 2'd0) ld_byte = bus.rd_data[DATA_W-1 -: 8];
    else                     ld_byte = data_sr_q[DATA_W-1 -: 8];
    crc_next = crc_byte(crc_q, ld_byte);
    launch   = rdy_q & tick & ((state_q == StLoad) | (state_q == StCrcLo) | (state_q == StCrcHi));
  end

  // Frame sequencer, byte fetch, CRC and serializer with registered outputs.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= StIdle;
      kind_q       <= KindData;
      start_sync_q <= '0;
      addr_q       <= '0;
      func_q       <= '0;
      code_q       <= '0;
      nbytes_q     <= '0;
      exc_q        <= 1'b0;
      idx_q        <= '0;
      reg_idx_q    <= '0;
      bsel_q       <= '0;
      rd_pend_q    <= '0;
      data_sr_q    <= '0;
      nxt_q        <= '0;
      rdy_q        <= 1'b0;
      sr_q         <= '1;
      baud_q       <= '0;
      bit_q        <= '0;
      crc_q        <= 16'hFFFF;
      tx_q         <= 1'b1;
      en_q         <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= '0;
    end else begin
      start_sync_q <= {start_sync_q[1:0], bus.tx_start};
      done_q       <= 1'b0;
      rd_en_q      <= 1'b0;
      if (state_q != StIdle) baud_q <= tick ? '0 : baud_q + 1'b1;
      unique case (state_q)
        StIdle: begin
          if (start_edge) begin
            addr_q    <= bus.slave_addr;
            func_q    <= bus.func_code;
            exc_q     <= bus.exc_req | force_exc;
            code_q    <= bus.exc_req ? bus.exc_code : 8'h03;
            nbytes_q  <= prod[7:0];
            busy_q    <= 1'b1;
            en_q      <= 1'b1;
            baud_q    <= '0;
            bit_q     <= '0;
            idx_q     <= '0;
            reg_idx_q <= '0;
            bsel_q    <= '0;
            rd_pend_q <= '0;
            rdy_q     <= 1'b0;
            crc_q     <= 16'hFFFF;
            state_q   <= StPreGap;
          end
        end
        StPreGap: begin
          if (tick) begin
            bit_q <= bit_q + 8'd1;
            // Final gap bit runs in LOAD so the first byte is ready on time.
            if (bit_q == GapTurn) state_q <= StLoad;
          end
        end
        StLoad: begin
          if (!rdy_q) begin
            if (is_hdr) begin
              nxt_q  <= ld_byte;
              crc_q  <= crc_next;
              idx_q  <= idx_q + 9'd1;
              kind_q <= KindData;
              rdy_q  <= 1'b1;
            end else if (is_data) begin
              if (bsel_q == 2'd0 && rd_pend_q == 2'd0) begin
                rd_en_q   <= 1'b1;
                rd_addr_q <= reg_idx_q;
                rd_pend_q <= 2'd1;
              end else if (bsel_q == 2'd0 && rd_pend_q == 2'd1) begin
                rd_pend_q <= 2'd2;
              end else begin
                nxt_q     <= ld_byte;
                crc_q     <= crc_next;
                idx_q     <= idx_q + 9'd1;
                kind_q    <= KindData;
                rdy_q     <= 1'b1;
                rd_pend_q <= 2'd0;
                data_sr_q <= (bsel_q == 2'd0) ? (bus.rd_data << 8) : (data_sr_q << 8);
                if (bsel_q == 2'd0) reg_idx_q <= reg_idx_q + 8'd1;
                bsel_q    <= (bsel_q == BselLast) ? 2'd0 : bsel_q + 2'd1;
              end
            end else begin
              state_q <= StCrcLo;
            end
          end
        end
        StCrcLo: begin
          if (!rdy_q) begin
            nxt_q  <= crc_q[7:0];
            kind_q <= KindCrcLo;
            rdy_q  <= 1'b1;
          end
        end
        StCrcHi: begin
          if (!rdy_q) begin
            nxt_q  <= crc_q[15:8];
            kind_q <= KindCrcHi;
            rdy_q  <= 1'b1;
          end
        end
        StSend: begin
          if (tick) begin
            if (bit_q == BitLast) begin
              bit_q   <= '0;
              state_q <= StPostGap;
            end else begin
              tx_q  <= sr_q[0];
              sr_q  <= {1'b1, sr_q[10:1]};
              bit_q <= bit_q + 8'd1;
              // Hand over at the start of the last stop bit to keep bytes back-to-back.
              if (bit_q == BitTurn) begin
                if (kind_q == KindData) state_q <= StLoad;
                else if (kind_q == KindCrcLo) state_q <= StCrcHi;
              end
            end
          end
        end
        StPostGap: begin
          if (tick) begin
            bit_q <= bit_q + 8'd1;
            if (bit_q == GapLast) begin
              en_q    <= 1'b0;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= StDone;
            end
          end
        end
        StDone: begin
          rd_addr_q <= '0;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
      if (launch) begin
        tx_q    <= 1'b0;
        sr_q    <= char_bits(nxt_q);
        bit_q   <= '0;
        rdy_q   <= 1'b0;
        state_q <= StSend;
      end
    end
  end

  assign bus.rs485_tx      = tx_q;
  assign bus.rs485_tx_en   = en_q;
  assign bus.busy          = busy_q;
  assign bus.response_done = done_q;
  assign bus.rd_en         = rd_en_q;
  assign bus.rd_addr       = rd_addr_q;

endmodule

// File: tb/tb_rtu_frame_tx.sv
// Directed bench for rtu_frame_tx: two instances (16-bit/8N1 and 32-bit/8E2),
// a UART line decoder and an expected-byte scoreboard.
module tb_rtu_frame_tx;

  localparam int unsigned ClkFreq  = 80;
  localparam int unsigned Baud     = 10;
  localparam int unsigned Bps      = 8;
  localparam int unsigned Gap      = 35;
  localparam int unsigned MaxBytes = 250;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rtu_frame_tx_if #(.DATA_W(16)) if0 ();
  rtu_frame_tx_if #(.DATA_W(32)) if1 ();

  rtu_frame_tx #(
    .CLK_FREQ(ClkFreq), .BAUD_RATE(Baud), .DATA_W(16), .PARITY(0), .STOP_BITS(1),
    .GAP_BITS(Gap), .MAX_BYTES(MaxBytes)
  ) u0 (
    .clk_in(clk), .rst_n_in(rst_n), .bus(if0)
  );

  rtu_frame_tx #(
    .CLK_FREQ(ClkFreq), .BAUD_RATE(Baud), .DATA_W(32), .PARITY(2), .STOP_BITS(2),
    .GAP_BITS(Gap), .MAX_BYTES(MaxBytes)
  ) u1 (
    .clk_in(clk), .rst_n_in(rst_n), .bus(if1)
  );

  logic [15:0] mem0 [0:3];
  logic [31:0] mem1 [0:3];
  logic [7:0]  rd_log [$];
  logic [7:0]  exp_q [$];
  int          cyc = 0;
  int          done_cnt = 0;
  int          n_assert = 0;
  int          n_fail = 0;
  int          sel = 0;
  int          t_en, t_start, t_prev;
  bit          first;
  logic        line_m, en_m, done_m, busy_m;

  // Register map model and read/done monitors.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (if0.rd_en) begin
      if0.rd_data <= mem0[if0.rd_addr[1:0]];
      rd_log.push_back(if0.rd_addr);
    end
    if (if1.rd_en) begin
      if1.rd_data <= mem1[if1.rd_addr[1:0]];
      rd_log.push_back(if1.rd_addr);
    end
    if (if0.response_done || if1.response_done) done_cnt <= done_cnt + 1;
  end

  always_comb begin
    line_m = (sel == 1) ? if1.rs485_tx : if0.rs485_tx;
    en_m   = (sel == 1) ? if1.rs485_tx_en : if0.rs485_tx_en;
    done_m = (sel == 1) ? if1.response_done : if0.response_done;
    busy_m = (sel == 1) ? if1.busy : if0.busy;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int nbits();
    return (sel == 1) ? 12 : 10;
  endfunction

  task automatic add_crc();
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (exp_q[k]) begin
      c ^= {8'h00, exp_q[k]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    exp_q.push_back(c[7:0]);
    exp_q.push_back(c[15:8]);
  endtask

  task automatic setup(input int s, input logic [7:0] a, input logic [7:0] f,
                       input logic [7:0] q, input logic e, input logic [7:0] code);
    sel = s;
    if (s == 0) begin
      if0.slave_addr = a; if0.func_code = f; if0.tx_quantity = q;
      if0.exc_req = e; if0.exc_code = code;
    end else begin
      if1.slave_addr = a; if1.func_code = f; if1.tx_quantity = q;
      if1.exc_req = e; if1.exc_code = code;
    end
    rd_log.delete();
    done_cnt = 0;
  endtask

  task automatic frame_begin();
    int n;
    if (sel == 0) if0.tx_start = 1'b1; else if1.tx_start = 1'b1;
    n = 0;
    while (en_m !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if0.tx_start = 1'b0;
    if1.tx_start = 1'b0;
    check("en_rise", 32'(en_m), 1);
    check("busy_rise", 32'(busy_m), 1);
    t_en  = cyc;
    first = 1'b1;
  endtask

  task automatic rx_byte();
    logic [11:0] bits;
    logic [7:0]  data;
    logic        s;
    bit          stable;
    int          n;
    n = 0;
    while (line_m !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (line_m !== 1'b0) begin
      check("rx_start_timeout", 32'(line_m), 0);
      return;
    end
    t_start = cyc;
    if (first) check("pre_gap_clocks", 32'(t_start - t_en), Gap * Bps);
    else       check("char_spacing", 32'(t_start - t_prev), 32'(nbits() * Bps));
    stable = 1'b1;
    bits   = '0;
    for (int i = 0; i < nbits(); i++) begin
      s = line_m;
      bits[i] = s;
      for (int j = 1; j < Bps; j++) begin
        @(negedge clk);
        if (line_m !== s) stable = 1'b0;
      end
      @(negedge clk);
    end
    data = bits[8:1];
    check("bit_period", 32'(stable), 1);
    check("start_bit", 32'(bits[0]), 0);
    if (exp_q.size() == 0) check("unexpected_byte", 32'(data), 32'hFFFF_FFFF);
    else check("byte", 32'(data), 32'(exp_q.pop_front()));
    if (sel == 1) begin
      check("parity_even", 32'(bits[9]), 32'(^data));
      check("stop_bits", 32'(bits[11:10]), 3);
    end else begin
      check("stop_bit", 32'(bits[9]), 1);
    end
    t_prev = t_start;
    first  = 1'b0;
  endtask

  task automatic frame_end();
    int n, t_end;
    bit ones;
    t_end = t_prev + nbits() * Bps;
    ones  = 1'b1;
    n     = 0;
    while (en_m === 1'b1 && n < 2000) begin
      if (line_m !== 1'b1) ones = 1'b0;
      @(negedge clk);
      n++;
    end
    check("en_fall", 32'(en_m), 0);
    check("post_gap_clocks", 32'(cyc - t_end), Gap * Bps);
    check("post_gap_idle", 32'(ones), 1);
    check("done_with_en_fall", 32'(done_m), 1);
    check("busy_drop", 32'(busy_m), 0);
    @(negedge clk);
    check("done_one_cycle", 32'(done_m), 0);
    check("scoreboard_empty", 32'(exp_q.size()), 0);
  endtask

  task automatic run_frame();
    int n;
    n = exp_q.size();
    frame_begin();
    repeat (n) rx_byte();
    frame_end();
  endtask

  task automatic check_rd(input int cnt, input logic [7:0] a0, input logic [7:0] a1);
    check("rd_count", 32'(rd_log.size()), 32'(cnt));
    if (cnt > 0) check("rd_addr_0", (rd_log.size() > 0) ? 32'(rd_log[0]) : 32'hFF, 32'(a0));
    if (cnt > 1) check("rd_addr_1", (rd_log.size() > 1) ? 32'(rd_log[1]) : 32'hFF, 32'(a1));
    check("done_count", 32'(done_cnt), 1);
  endtask

  initial begin
    if0.tx_start = 1'b0; if0.slave_addr = '0; if0.func_code = '0; if0.tx_quantity = '0;
    if0.exc_req = 1'b0;  if0.exc_code = '0;
    if1.tx_start = 1'b0; if1.slave_addr = '0; if1.func_code = '0; if1.tx_quantity = '0;
    if1.exc_req = 1'b0;  if1.exc_code = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(if0.rs485_tx), 1);
    check("rst_tx_en", 32'(if0.rs485_tx_en), 0);
    check("rst_busy", 32'(if0.busy), 0);
    check("rst_rd_en", 32'(if0.rd_en), 0);
    check("rst_done", 32'(if0.response_done), 0);
    check("rst_rd_addr", 32'(if0.rd_addr), 0);
    check("rst_tx_u1", 32'(if1.rs485_tx), 1);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // 16-bit read of 0x0000.
    mem0[0] = 16'h0000;
    setup(0, 8'h01, 8'h03, 8'd1, 1'b0, 8'h00);
    exp_q = '{8'h01, 8'h03, 8'h02, 8'h00, 8'h00, 8'hB8, 8'h44};
    run_frame();
    check_rd(1, 8'h00, 8'h00);

    // 16-bit read of 0x0001.
    repeat (5) @(negedge clk);
    mem0[0] = 16'h0001;
    setup(0, 8'h01, 8'h03, 8'd1, 1'b0, 8'h00);
    exp_q = '{8'h01, 8'h03, 8'h02, 8'h00, 8'h01, 8'h79, 8'h84};
    run_frame();
    check_rd(1, 8'h00, 8'h00);

    // Requested exception.
    repeat (5) @(negedge clk);
    setup(0, 8'h01, 8'h03, 8'd1, 1'b1, 8'h02);
    exp_q = '{8'h01, 8'h83, 8'h02, 8'hC0, 8'hF1};
    run_frame();
    check_rd(0, 8'h00, 8'h00);

    // Quantity 0 forces exception 03.
    repeat (5) @(negedge clk);
    setup(0, 8'h01, 8'h03, 8'd0, 1'b0, 8'h00);
    exp_q = '{8'h01, 8'h83, 8'h03, 8'h01, 8'h31};
    run_frame();
    check_rd(0, 8'h00, 8'h00);

    // 32-bit, two registers, even parity, two stop bits, retrigger mid-frame.
    repeat (5) @(negedge clk);
    mem1[0] = 32'h11223344;
    mem1[1] = 32'h55667788;
    setup(1, 8'h01, 8'h03, 8'd2, 1'b0, 8'h00);
    exp_q = '{8'h01, 8'h03, 8'h08, 8'h11, 8'h22, 8'h33, 8'h44,
              8'h55, 8'h66, 8'h77, 8'h88};
    add_crc();
    fork
      begin
        repeat (600) @(negedge clk);
        if1.tx_start = 1'b1;
        repeat (3) @(negedge clk);
        if1.tx_start = 1'b0;
      end
    join_none
    run_frame();
    check_rd(2, 8'h00, 8'h01);
    check("rd_addr_idle", 32'(if1.rd_addr), 0);
    repeat (60) @(negedge clk);
    check("retrigger_no_frame_en", 32'(en_m), 0);
    check("retrigger_no_frame_busy", 32'(busy_m), 0);

    // 63 x 4 = 252 bytes exceeds the limit.
    setup(1, 8'h01, 8'h03, 8'd63, 1'b0, 8'h00);
    exp_q = '{8'h01, 8'h83, 8'h03, 8'h01, 8'h31};
    run_frame();
    check_rd(0, 8'h00, 8'h00);

    // Reset during a data byte, then a clean frame.
    repeat (5) @(negedge clk);
    mem0[0] = 16'h1234;
    mem0[1] = 16'hABCD;
    setup(0, 8'h01, 8'h03, 8'd2, 1'b0, 8'h00);
    exp_q = '{8'h01, 8'h03, 8'h04, 8'h12, 8'h34, 8'hAB, 8'hCD};
    add_crc();
    frame_begin();
    repeat (3) rx_byte();
    repeat (24) @(negedge clk);
    check("line_low_before_reset", 32'(line_m), 0);
    #2 rst_n = 1'b0;
    #1;
    check("abort_tx", 32'(if0.rs485_tx), 1);
    check("abort_tx_en", 32'(if0.rs485_tx_en), 0);
    check("abort_busy", 32'(if0.busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    setup(0, 8'h01, 8'h03, 8'd2, 1'b0, 8'h00);
    exp_q = '{8'h01, 8'h03, 8'h04, 8'h12, 8'h34, 8'hAB, 8'hCD};
    add_crc();
    run_frame();
    check_rd(2, 8'h00, 8'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
